// File: rtl/switch_debouncer_if.sv
// Switch conditioning bundle: raw pins in, debounced level, edge strobes and busy out.
interface switch_debouncer_if #(
  parameter int unsigned WIDTH = 4
);
  logic [WIDTH-1:0] sw_raw;
  logic [WIDTH-1:0] sw_clean;
  logic [WIDTH-1:0] sw_rise;
  logic [WIDTH-1:0] sw_fall;
  logic             busy;

  // master drives the pins and observes the conditioned outputs
  modport master (
    output sw_raw,
    input  sw_clean,
    input  sw_rise,
    input  sw_fall,
    input  busy
  );

  modport slave (
    input  sw_raw,
    output sw_clean,
    output sw_rise,
    output sw_fall,
    output busy
  );
endinterface

// File: rtl/switch_debouncer.sv
// Per-bit two-flop synchronizer followed by a stability counter; a new level is accepted
// only after it has held for STABLE_CYCLES clocks, with one-cycle rise/fall strobes.
module switch_debouncer #(
  parameter int unsigned WIDTH         = 4,
  parameter int unsigned STABLE_CYCLES = 50000,
  parameter int unsigned CNT_W         = 16
) (
  input logic                clk,
  input logic                reset,
  switch_debouncer_if.slave  sw_if
);

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(STABLE_CYCLES - 1);

  logic [WIDTH-1:0]            sync1_q, sync2_q;
  logic [WIDTH-1:0]            clean_q, clean_d;
  logic [WIDTH-1:0]            rise_q, rise_d;
  logic [WIDTH-1:0]            fall_q, fall_d;
  logic [WIDTH-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic                        busy;

  always_comb begin
    clean_d = clean_q;
    cnt_d   = cnt_q;
    for (int i = 0; i < int'(WIDTH); i++) begin
      if (sync2_q[i] == clean_q[i]) begin
        // any return to the accepted level restarts the wait
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CntMax) begin
        clean_d[i] = sync2_q[i];
        cnt_d[i]   = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
    rise_d = ~clean_q & clean_d;
    fall_d = clean_q & ~clean_d;
  end

  always_comb begin
    busy = 1'b0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      busy = busy | (cnt_q[i] != '0);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      clean_q <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sw_if.sw_raw;
      sync2_q <= sync1_q;
      clean_q <= clean_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      cnt_q   <= cnt_d;
    end
  end

  assign sw_if.sw_clean = clean_q;
  assign sw_if.sw_rise  = rise_q;
  assign sw_if.sw_fall  = fall_q;
  assign sw_if.busy     = busy;

endmodule

// File: tb/tb_switch_debouncer.sv
// Directed bench for switch_debouncer with WIDTH=4, STABLE_CYCLES=4; expected edges hand-computed.
module tb_switch_debouncer;

  localparam int unsigned W = 4;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  switch_debouncer_if #(.WIDTH(W)) sif ();

  switch_debouncer #(
    .WIDTH        (W),
    .STABLE_CYCLES(4),
    .CNT_W        (16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .sw_if (sif.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Advance one active edge and sample just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle(input logic [W-1:0] v);
    sif.sw_raw = v;
    repeat (10) tick();
  endtask

  logic [W-1:0] ev;
  logic         busy_seen;
  int           pulses;

  initial begin
    // 1: reset with switches high, then full latency from first capture
    reset      = 1'b1;
    sif.sw_raw = 4'hF;
    repeat (3) tick();
    check("rst_clean", sif.sw_clean, 4'h0);
    check("rst_rise", sif.sw_rise, 4'h0);
    check("rst_fall", sif.sw_fall, 4'h0);
    check("rst_busy", {3'b000, sif.busy}, 4'h0);
    reset = 1'b0;
    tick();                               // edge k: first capture
    check("rel_clean", sif.sw_clean, 4'h0);
    check("rel_busy", {3'b000, sif.busy}, 4'h0);
    repeat (4) tick();                    // k+4
    check("t1_k4_clean", sif.sw_clean, 4'h0);
    check("t1_k4_busy", {3'b000, sif.busy}, 4'h1);
    tick();                               // k+5
    check("t1_clean", sif.sw_clean, 4'hF);
    check("t1_rise", sif.sw_rise, 4'hF);
    check("t1_busy", {3'b000, sif.busy}, 4'h0);
    tick();
    check("t1_rise_end", sif.sw_rise, 4'h0);

    // 2: clean step on bit 0
    settle(4'h0);
    check("t2_pre", sif.sw_clean, 4'h0);
    check("t2_fall_done", sif.sw_fall, 4'h0);
    sif.sw_raw = 4'h1;
    tick();                               // k
    tick();
    tick();                               // k+2
    check("t2_busy_mid", {3'b000, sif.busy}, 4'h1);
    tick();
    tick();                               // k+4
    check("t2_k4_clean", sif.sw_clean, 4'h0);
    tick();                               // k+5
    check("t2_clean", sif.sw_clean, 4'h1);
    check("t2_rise", sif.sw_rise, 4'h1);
    check("t2_fall", sif.sw_fall, 4'h0);
    check("t2_busy_end", {3'b000, sif.busy}, 4'h0);
    tick();
    check("t2_rise_end", sif.sw_rise, 4'h0);

    // 3: bit 1 high for exactly three cycles is rejected
    ev         = '0;
    busy_seen  = 1'b0;
    sif.sw_raw = 4'h3;
    for (int j = 0; j < 12; j++) begin
      if (j == 3) sif.sw_raw = 4'h1;
      tick();
      ev        = ev | sif.sw_rise | sif.sw_fall;
      busy_seen = busy_seen | sif.busy;
      if (sif.sw_clean !== 4'h1) ev = ev | 4'h8;
    end
    check("t3_no_event", ev, 4'h0);
    check("t3_clean", sif.sw_clean, 4'h1);
    check("t3_busy_seen", {3'b000, busy_seen}, 4'h1);
    check("t3_busy_end", {3'b000, sif.busy}, 4'h0);

    // 4: bounce 1,0,1,0,1 on bit 2, then hold 1
    pulses = 0;
    for (int j = 0; j < 5; j++) begin
      sif.sw_raw = (j % 2 == 0) ? 4'h5 : 4'h1;
      tick();                             // last iteration is edge L
      if (sif.sw_rise[2]) pulses++;
    end
    for (int e = 1; e <= 8; e++) begin
      tick();
      if (sif.sw_rise[2]) pulses++;
      if (e == 4) check("t4_L4_clean", sif.sw_clean, 4'h1);
      if (e == 5) begin
        check("t4_L5_clean", sif.sw_clean, 4'h5);
        check("t4_L5_rise", sif.sw_rise, 4'h4);
      end
    end
    check("t4_pulses", pulses[W-1:0], 4'h1);

    // 5: simultaneous rise and fall
    settle(4'h3);
    check("t5_pre", sif.sw_clean, 4'h3);
    sif.sw_raw = 4'hC;
    tick();                               // k
    repeat (4) tick();                    // k+4
    check("t5_k4_clean", sif.sw_clean, 4'h3);
    tick();                               // k+5
    check("t5_clean", sif.sw_clean, 4'hC);
    check("t5_rise", sif.sw_rise, 4'hC);
    check("t5_fall", sif.sw_fall, 4'h3);
    tick();
    check("t5_rise_end", sif.sw_rise, 4'h0);
    check("t5_fall_end", sif.sw_fall, 4'h0);

    // 6: reset while cnt[3] is 2, then full latency again
    settle(4'h0);
    check("t6_pre", sif.sw_clean, 4'h0);
    sif.sw_raw = 4'h8;
    repeat (4) tick();                    // k+3: cnt[3] == 2
    check("t6_busy_pre", {3'b000, sif.busy}, 4'h1);
    #2;
    reset = 1'b1;
    #1;
    check("t6_rst_busy", {3'b000, sif.busy}, 4'h0);
    check("t6_rst_clean", sif.sw_clean, 4'h0);
    tick();
    tick();
    reset = 1'b0;
    tick();                               // k'
    check("t6_rel_busy", {3'b000, sif.busy}, 4'h0);
    repeat (4) tick();                    // k'+4
    check("t6_k4_clean", sif.sw_clean, 4'h0);
    tick();                               // k'+5
    check("t6_clean", sif.sw_clean, 4'h8);
    check("t6_rise", sif.sw_rise, 4'h8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
